ife_rle_out: RTL and testbench

Downstream readout stage for the image filter engine. Once the filter has written a full 128x128 8-bit result frame into the result memory, this block scans the frame in raster order. It thresholds each pixel to one bit and emits run-length tokens over a valid/ready stream. Each image row is encoded independently, so no run crosses a row boundary.

---
 rtl/ife_rle_out.sv | 156 +++++++++++++++
 tb/tb_ife_rle_out.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ife_rle_out.sv
// rtl/ife_rle_out.sv - thresholds a 128x128 result frame and emits per-row run-length tokens
// Optional macro IFE_RLE_STAT_EN adds the ones_cnt frame statistic output.
module ife_rle_out #(
  parameter int IMG_W   = 128,
  parameter int IMG_PIX = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  thresh,
  output logic [13:0] raddr,
  input  logic [7:0]  rdata,
  output logic        busy,
  output logic        done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_bit,
  output logic [7:0]  out_len,
  output logic        out_last
`ifdef IFE_RLE_STAT_EN
  ,
  output logic [14:0] ones_cnt
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EVAL, S_FLUSH, S_DONE} state_t;
  state_t state, state_nx;

  logic [13:0] idx;
  logic [7:0]  thresh_q;
  logic        cur;
  logic [7:0]  len;
  // set while the one-pixel run of a split column 127 still waits to be loaded
  logic        second;

  logic       p, col_first, col_last, pix_last, can_load, split;
  logic       emit, emit_bit, emit_last, commit, advance;
  logic [7:0] emit_len;

  assign p         = rdata >= thresh_q;
  assign col_first = idx[6:0] == 7'd0;
  assign col_last  = idx[6:0] == 7'(IMG_W - 1);
  assign pix_last  = idx == 14'(IMG_PIX - 1);
  assign can_load  = !out_valid || out_ready;
  assign split     = !second && !col_first && (p != cur);
  assign raddr     = idx;

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    done      = 1'b0;
    emit      = 1'b0;
    emit_bit  = cur;
    emit_len  = len;
    emit_last = 1'b0;
    commit    = 1'b0;
    advance   = 1'b0;
    unique case (state)
      S_IDLE: if (start) state_nx = S_FETCH;
      S_FETCH: begin
        busy     = 1'b1;
        state_nx = S_EVAL;
      end
      S_EVAL: begin
        busy = 1'b1;
        if (second) begin
          // run register already holds (p,1) from the first half of the split
          emit      = 1'b1;
          emit_last = pix_last;
          advance   = can_load;
        end else if (split) begin
          emit    = 1'b1;
          commit  = can_load;
          advance = can_load && !col_last;
        end else if (col_last) begin
          emit      = 1'b1;
          emit_len  = len + 8'd1;
          emit_last = pix_last;
          commit    = can_load;
          advance   = can_load;
        end else begin
          commit  = 1'b1;
          advance = 1'b1;
        end
        if (advance) state_nx = pix_last ? S_FLUSH : S_FETCH;
      end
      S_FLUSH: begin
        busy = 1'b1;
        if (out_valid && out_ready && out_last) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx       <= '0;
      thresh_q  <= '0;
      cur       <= 1'b0;
      len       <= '0;
      second    <= 1'b0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_len   <= '0;
      out_last  <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        thresh_q <= thresh;
        idx      <= '0;
        second   <= 1'b0;
      end
      if (commit) begin
        if (col_first || p != cur) begin
          cur <= p;
          len <= 8'd1;
        end else begin
          len <= len + 8'd1;
        end
      end
      if (state == S_EVAL) begin
        if (second) begin
          if (can_load) second <= 1'b0;
        end else if (split && col_last && can_load) begin
          second <= 1'b1;
        end
      end
      if (advance) idx <= idx + 14'd1;
      if (emit && can_load) begin
        out_valid <= 1'b1;
        out_bit   <= emit_bit;
        out_len   <= emit_len;
        out_last  <= emit_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef IFE_RLE_STAT_EN
  always_ff @(posedge clk) begin
    if (!reset)                   ones_cnt <= '0;
    else if (state == S_IDLE && start) ones_cnt <= '0;
    else if (commit && p)         ones_cnt <= ones_cnt + 15'd1;
  end
`endif

endmodule

// File: tb/tb_ife_rle_out.sv
// tb/tb_ife_rle_out.sv - randomized scoreboard bench for ife_rle_out
// Honours IFE_RLE_STAT_EN for the ones_cnt port.
module tb_ife_rle_out;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  thresh = 8'd0;
  logic [7:0]  rdata;
  logic [13:0] raddr;
  logic        busy, done, out_valid, out_bit, out_last;
  logic [7:0]  out_len;
`ifdef IFE_RLE_STAT_EN
  logic [14:0] ones_cnt;
`endif

  logic [7:0] mem [0:16383];
  logic [9:0] exp_q[$];
  logic [9:0] rx_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int rdy_mode = 0;
  int exp_ones = 0;

  always #5 clk = ~clk;
  always @(posedge clk) rdata <= mem[raddr];

  ife_rle_out dut (
    .clk(clk), .reset(reset), .start(start), .thresh(thresh),
    .raddr(raddr), .rdata(rdata), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .out_len(out_len), .out_last(out_last)
`ifdef IFE_RLE_STAT_EN
    , .ones_cnt(ones_cnt)
`endif
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: each row is binarised and split into maximal runs; row end closes the run.
  task automatic build_model(input logic [7:0] th);
    exp_q.delete();
    exp_ones = 0;
    for (int r = 0; r < 128; r++) begin
      logic rb;
      int   rl;
      rb = 1'b0;
      rl = 0;
      for (int c = 0; c < 128; c++) begin
        logic b;
        b = (mem[r*128+c] >= th);
        exp_ones += int'(b);
        if (c == 0 || b != rb) begin
          if (c != 0) exp_q.push_back({1'b0, rb, 8'(rl)});
          rb = b;
          rl = 1;
        end else begin
          rl++;
        end
      end
      exp_q.push_back({(r == 127), rb, 8'(rl)});
    end
  endtask

  task automatic fill_frame1();
    logic [7:0] v;
    for (int r = 0; r < 128; r++) begin
      v = 8'($urandom);
      for (int c = 0; c < 128; c++) begin
        if ($urandom_range(0, 15) == 0) v = 8'($urandom);
        mem[r*128+c] = v;
      end
    end
    for (int c = 0; c < 128; c++) begin
      mem[c]       = (c < 10) ? 8'd200 : 8'd0;
      mem[128+c]   = 8'd129;
      mem[256+c]   = (c == 126) ? 8'd255 : 8'd0;
      mem[5*128+c] = (c == 127) ? 8'd255 : 8'd0;
    end
    mem[128] = 8'd128;
    mem[129] = 8'd127;
  endtask

  task automatic do_start(input logic [7:0] th);
    build_model(th);
    rx_q.delete();
    thresh = th;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    thresh = ~th;
    check("busy_rise", busy, 1);
    check("raddr_first", raddr, 0);
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 70000) begin
      @(posedge clk); #1;
      lat++;
    end
    check("done_seen", done, 1);
    check("busy_at_done", busy, 0);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
  endtask

  task automatic check_reset_values();
    check("rst_raddr", raddr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bit", out_bit, 0);
    check("rst_out_len", out_len, 0);
    check("rst_out_last", out_last, 0);
`ifdef IFE_RLE_STAT_EN
    check("rst_ones_cnt", ones_cnt, 0);
`endif
  endtask

  // Consumer: 0 = always ready, 1 = random, 2 = stalled.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks held tokens stay put.
  initial begin
    logic       hold_prev;
    logic [9:0] hold_tok;
    logic [9:0] tok;
    hold_prev = 1'b0;
    hold_tok  = '0;
    forever begin
      @(negedge clk);
      tok = {out_last, out_bit, out_len};
      if (!reset) begin
        hold_prev = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (hold_prev) begin
          check("hold_valid", out_valid, 1);
          check("hold_token", tok, hold_tok);
        end
        if (out_valid && out_ready) begin
          rx_q.push_back(tok);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL token_extra: got %0d with nothing expected", tok);
          end else begin
            check("token", tok, exp_q.pop_front());
          end
        end
        hold_prev = out_valid && !out_ready;
        hold_tok  = tok;
      end
    end
  end

  initial begin
    int lat, n, d0, exp_n;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Frame 1: mixed rows, consumer stalled until after the first row end, then random.
    fill_frame1();
    rdy_mode = 2;
    d0 = done_cnt;
    do_start(8'd128);
    exp_n = exp_q.size() + 0;
    n = 0;
    while (raddr != 14'd115 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_stall_point", (n < 1000), 1);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (i >= 30) check("stall_raddr", raddr, 127);
    end
    rdy_mode = 1;
    wait_done(lat);
    check("frame1_token_count", rx_q.size(), exp_n);
    check("frame1_tok0", (rx_q.size() > 0) ? rx_q[0] : 10'h3ff, {2'b01, 8'd10});
    check("frame1_tok1", (rx_q.size() > 1) ? rx_q[1] : 10'h3ff, {2'b00, 8'd118});
    check("frame1_drained", exp_q.size(), 0);
    check("frame1_done_count", done_cnt - d0, 1);
`ifdef IFE_RLE_STAT_EN
    check("frame1_ones_cnt", ones_cnt, exp_ones);
    repeat (3) @(posedge clk);
    #1;
    check("frame1_ones_hold", ones_cnt, exp_ones);
`endif

    // Frame 2: aborted by reset at pixel 5000.
    rdy_mode = 1;
    repeat (3) @(posedge clk);
    #1;
    d0 = done_cnt;
    do_start(8'd128);
    n = 0;
    while (raddr != 14'd5000 && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_abort_point", (n < 20000), 1);
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_values();
    reset = 1'b1;
    exp_q.delete();
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_idle_busy", busy, 0);

    // Frame 3: restart with thresh 0, consumer always ready.
    rdy_mode = 0;
    d0 = done_cnt;
    do_start(8'd0);
    wait_done(lat);
    check("restart_latency_ok", (lat >= 32770 && lat <= 32900), 1);
    check("restart_token_count", rx_q.size(), 128);
    check("restart_last_token", (rx_q.size() > 0) ? rx_q[rx_q.size()-1] : 10'h0, {2'b11, 8'd128});
    check("restart_drained", exp_q.size(), 0);
    check("restart_done_count", done_cnt - d0, 1);
`ifdef IFE_RLE_STAT_EN
    check("restart_ones_cnt", ones_cnt, 16384);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
